// File: rtl/spi_slave_stream.sv
// Oversampled SPI slave (all CPOL/CPHA modes, multi-word frames) with valid/ready word streams.
// Define SPI_ERR_FLAGS_EN to add the sticky overrun_o/underrun_o outputs.
module spi_slave_stream #(
  parameter int unsigned WORD_BITS = 24,
  parameter int unsigned SYNC_FF   = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic                 sck_i,
  input  logic                 cs_i,
  input  logic                 sdi_i,
  output logic                 sdo_o,
  output logic                 sdo_oe_o,
  input  logic [WORD_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [WORD_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i
`ifdef SPI_ERR_FLAGS_EN
  ,
  output logic                 overrun_o,
  output logic                 underrun_o
`endif
);

  localparam int unsigned CNT_W = $clog2(WORD_BITS + 1);
  localparam int unsigned SH_W  = WORD_BITS - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_oe_nxt;

  logic [SYNC_FF-1:0]    r_sck_sync;
  logic [SYNC_FF-1:0]    r_cs_sync;
  logic [SYNC_FF-1:0]    r_sdi_sync;
  logic                  r_sck_d;
  logic                  r_cs_d;

  logic                  r_cpol;
  logic                  r_cpha;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [SH_W-1:0]       r_tx_sh;
  logic [SH_W-1:0]       r_rx_sh;
  logic                  r_first;
  logic                  r_reload;
  logic                  r_armed;
  logic                  r_peek_v;
  logic                  r_sdo;
  logic                  r_oe;
  logic                  r_tx_ready;
  logic [WORD_BITS-1:0]  r_rx_data;
  logic                  r_rx_valid;

  logic w_sck, w_cs, w_sdi;
  logic w_sck_rise, w_sck_fall, w_cs_fall;
  logic w_lead, w_trail, w_active, w_sample, w_shift, w_word_done;
  logic w_tx_load, w_load_valid;
  logic [WORD_BITS-1:0] w_load_data;

  // Input synchronisers; cs resets low so a frame already in progress after reset is ignored.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sck_sync <= '0;
      r_cs_sync  <= '0;
      r_sdi_sync <= '0;
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_FF-2:0], sck_i};
      r_cs_sync  <= {r_cs_sync[SYNC_FF-2:0], cs_i};
      r_sdi_sync <= {r_sdi_sync[SYNC_FF-2:0], sdi_i};
      r_sck_d    <= w_sck;
      r_cs_d     <= w_cs;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_FF-1];
  assign w_cs       = r_cs_sync[SYNC_FF-1];
  assign w_sdi      = r_sdi_sync[SYNC_FF-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_fall  = r_cs_d & ~w_cs;
  assign w_lead     = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail    = r_cpol ? w_sck_rise : w_sck_fall;
  assign w_active   = (r_state == ST_SHIFT) & ~w_cs;
  assign w_sample   = w_active & (r_cpha ? w_trail : w_lead);
  assign w_shift    = w_active & (r_cpha ? w_lead : w_trail);
  assign w_word_done = w_sample & (r_bit_cnt == CNT_W'(WORD_BITS - 1));

  // CPHA=0 reloads in two steps: the next MSB is peeked on the trailing edge and the
  // word is only consumed on the following leading edge, so a frame's end never steals a word.
  assign w_tx_load = ((r_state == ST_LOAD) & ~w_cs)
                   | (w_shift & r_cpha & r_reload)
                   | (w_sample & r_armed);
  assign w_load_valid = (w_sample & r_armed) ? r_peek_v : tx_valid_i;
  assign w_load_data  = w_load_valid ? tx_data_i : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_oe_nxt    = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_cs_fall) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = w_cs ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (w_cs) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    w_oe_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_bit_cnt  <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_first    <= 1'b0;
      r_reload   <= 1'b0;
      r_armed    <= 1'b0;
      r_peek_v   <= 1'b0;
      r_sdo      <= 1'b0;
      r_oe       <= 1'b0;
      r_tx_ready <= 1'b0;
    end else begin
      r_tx_ready <= 1'b0;
      r_oe       <= w_oe_nxt;
      if (w_tx_load) begin
        r_tx_sh    <= w_load_data[SH_W-1:0];
        r_tx_ready <= w_load_valid;
      end
      if (w_state_nxt == ST_IDLE) begin
        r_bit_cnt <= '0;
        r_first   <= 1'b0;
        r_reload  <= 1'b0;
        r_armed   <= 1'b0;
        r_sdo     <= 1'b0;
      end else if (r_state == ST_LOAD) begin
        r_cpol    <= cpol_i;
        r_cpha    <= cpha_i;
        r_bit_cnt <= '0;
        r_first   <= cpha_i;
        r_reload  <= 1'b0;
        r_armed   <= 1'b0;
        r_sdo     <= w_load_data[WORD_BITS-1];
      end else begin
        if (w_sample) begin
          r_rx_sh   <= (r_rx_sh << 1) | SH_W'(w_sdi);
          r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
          r_armed   <= 1'b0;
          if (w_word_done) r_reload <= 1'b1;
        end
        if (w_shift) begin
          if (r_reload) begin
            r_reload <= 1'b0;
            if (r_cpha) begin
              r_sdo <= w_load_data[WORD_BITS-1];
            end else begin
              r_armed  <= 1'b1;
              r_peek_v <= tx_valid_i;
              r_sdo    <= tx_valid_i & tx_data_i[WORD_BITS-1];
            end
          end else if (r_first) begin
            r_first <= 1'b0;
          end else begin
            r_sdo   <= r_tx_sh[SH_W-1];
            r_tx_sh <= r_tx_sh << 1;
          end
        end
      end
    end
  end

  // Receive holding register: a freshly completed word always wins over acceptance.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_word_done) begin
      r_rx_data  <= {r_rx_sh, w_sdi};
      r_rx_valid <= 1'b1;
    end else if (rx_ready_i) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign sdo_o      = r_sdo;
  assign sdo_oe_o   = r_oe;
  assign tx_ready_o = r_tx_ready;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;

`ifdef SPI_ERR_FLAGS_EN
  logic r_overrun;
  logic r_underrun;
  logic w_ovr_evt;
  logic w_udr_evt;

  assign w_ovr_evt = w_word_done & r_rx_valid & ~rx_ready_i;
  assign w_udr_evt = w_tx_load & ~w_load_valid;

  // Sticky error flags, cleared at the start of each frame.
  always_ff @(posedge clk_i) begin
    if (reset_i || w_cs_fall) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_ovr_evt) r_overrun  <= 1'b1;
      if (w_udr_evt) r_underrun <= 1'b1;
    end
  end

  assign overrun_o  = r_overrun;
  assign underrun_o = r_underrun;
`endif

endmodule

// File: tb/tb_spi_slave_stream.sv
// Scoreboard bench for spi_slave_stream: an SPI master model drives frames, a monitor checks rx words.
`timescale 1ns/1ps
module tb_spi_slave_stream;
  localparam int unsigned W = 24;
  localparam int unsigned H = 6;

  logic         clk = 1'b0;
  logic         reset_i, cpol_i, cpha_i, sck_i, cs_i, sdi_i;
  logic         sdo_o, sdo_oe_o;
  logic [W-1:0] tx_data_i;
  logic         tx_valid_i, tx_ready_o;
  logic [W-1:0] rx_data_o;
  logic         rx_valid_o, rx_ready_i;
`ifdef SPI_ERR_FLAGS_EN
  logic         overrun_o, underrun_o;
`endif

  always #5 clk = ~clk;

  spi_slave_stream #(.WORD_BITS(W), .SYNC_FF(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .sck_i(sck_i), .cs_i(cs_i), .sdi_i(sdi_i), .sdo_o(sdo_o), .sdo_oe_o(sdo_oe_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i)
`ifdef SPI_ERR_FLAGS_EN
    , .overrun_o(overrun_o), .underrun_o(underrun_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tx_pulses = 0;
  logic [W-1:0] tx_src_q[$];
  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] exp_miso_q[$];
  logic [W-1:0] mosi_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Upstream word source: presents queued words, advances on each tx_ready_o pulse.
  initial begin
    tx_valid_i = 1'b0;
    tx_data_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_ready_o) begin
        tx_pulses++;
        tx_valid_i = 1'b0;
      end
      if (!tx_valid_i && tx_src_q.size() > 0) begin
        tx_data_i  = tx_src_q.pop_front();
        tx_valid_i = 1'b1;
      end
    end
  end

  // Rx monitor: every accepted word must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid_o && rx_ready_i) begin
        if (exp_rx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: got %h, required no word", rx_data_o);
        end else begin
          check("rx_word", 32'(rx_data_o), 32'(exp_rx_q.pop_front()));
        end
      end
    end
  end

  // SPI master: sends words from mosi_q, captures sdo at each sample edge.
  task automatic spi_frame(input bit cpol, input bit cpha, input int nwords, input int last_bits);
    logic [W-1:0] w, miso;
    logic cap;
    bit stable;
    int nb;
    cpol_i = cpol; cpha_i = cpha; sck_i = cpol;
    tick(4);
    cs_i = 1'b0;
    tick(H);
    check("oe_active", 32'(sdo_oe_o), 32'd1);
    stable = 1'b1;
    for (int k = 0; k < nwords; k++) begin
      w = mosi_q.pop_front();
      miso = '0;
      nb = (k == nwords - 1) ? last_bits : W;
      for (int b = 0; b < nb; b++) begin
        if (!cpha) begin
          sdi_i = w[W-1-b]; tick(H);
          sck_i = ~cpol; cap = sdo_o; tick(H);
          if (sdo_o !== cap) stable = 1'b0;
          sck_i = cpol;
        end else begin
          sck_i = ~cpol; sdi_i = w[W-1-b]; tick(H);
          sck_i = cpol; cap = sdo_o; tick(H);
          if (sdo_o !== cap) stable = 1'b0;
        end
        miso = {miso[W-2:0], cap};
      end
      if (nb == W) check("miso_word", 32'(miso), 32'(exp_miso_q.pop_front()));
    end
    if (!cpha) tick(H);
    check("sdo_stable", 32'(stable), 32'd1);
    cs_i = 1'b1;
    tick(8);
    check("oe_idle", 32'({sdo_oe_o, sdo_o}), 32'd0);
  endtask

  int p;
  logic [W-1:0] txw[3];
  logic [W-1:0] rxw[3];

  initial begin
    reset_i = 1'b1; cs_i = 1'b1; sck_i = 1'b0; sdi_i = 1'b0;
    cpol_i = 1'b0; cpha_i = 1'b0; rx_ready_i = 1'b1;
    tick(5);
    check("rst_sdo", 32'(sdo_o), 32'd0);
    check("rst_oe", 32'(sdo_oe_o), 32'd0);
    check("rst_tx_ready", 32'(tx_ready_o), 32'd0);
    check("rst_rx_data", 32'(rx_data_o), 32'd0);
    check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    reset_i = 1'b0;
    tick(5);

    // Single word in each of the four modes.
    for (int m = 0; m < 4; m++) begin
      p = tx_pulses;
      tx_src_q.push_back(24'hA5C3F0);
      mosi_q.push_back(24'h123456);
      exp_rx_q.push_back(24'h123456);
      exp_miso_q.push_back(24'hA5C3F0);
      spi_frame(m[1], m[0], 1, W);
      check("rx_data_hold", 32'(rx_data_o), 32'h123456);
      check("tx_pulses_1word", 32'(tx_pulses - p), 32'd1);
    end

    // Three back-to-back words, modes 0 and 3.
    txw[0] = 24'hC0FFEE; txw[1] = 24'h0BADF0; txw[2] = 24'h5EED42;
    rxw[0] = 24'hABCDEF; rxw[1] = 24'h13579B; rxw[2] = 24'h2468AC;
    for (int m = 0; m < 4; m += 3) begin
      p = tx_pulses;
      for (int k = 0; k < 3; k++) begin
        tx_src_q.push_back(txw[k]);
        mosi_q.push_back(rxw[k]);
        exp_rx_q.push_back(rxw[k]);
        exp_miso_q.push_back(txw[k]);
      end
      spi_frame(m[1], m[0], 3, W);
      check("tx_pulses_3word", 32'(tx_pulses - p), 32'd3);
    end

    // Underrun: nothing to send, master reads zeros.
    p = tx_pulses;
    mosi_q.push_back(24'h0F0F0F);
    exp_rx_q.push_back(24'h0F0F0F);
    exp_miso_q.push_back(24'h000000);
    spi_frame(1'b0, 1'b0, 1, W);
    check("tx_pulses_underrun", 32'(tx_pulses - p), 32'd0);
`ifdef SPI_ERR_FLAGS_EN
    check("underrun_flag", 32'(underrun_o), 32'd1);
    check("overrun_flag_clear", 32'(overrun_o), 32'd0);
`endif

    // Overrun: consumer stalls for two words, second word survives.
    rx_ready_i = 1'b0;
    tx_src_q.push_back(24'h777777);
    tx_src_q.push_back(24'h888888);
    mosi_q.push_back(24'h111111);
    mosi_q.push_back(24'h222222);
    exp_miso_q.push_back(24'h777777);
    exp_miso_q.push_back(24'h888888);
    exp_rx_q.push_back(24'h222222);
    spi_frame(1'b0, 1'b0, 2, W);
    check("overrun_valid", 32'(rx_valid_o), 32'd1);
    check("overrun_data", 32'(rx_data_o), 32'h222222);
`ifdef SPI_ERR_FLAGS_EN
    check("overrun_flag", 32'(overrun_o), 32'd1);
    check("underrun_flag_clear", 32'(underrun_o), 32'd0);
`endif
    rx_ready_i = 1'b1;
    tick(3);
    check("overrun_drained", 32'(rx_valid_o), 32'd0);

    // Reset mid-frame: slave stays quiet until the next cs fall.
    p = tx_pulses;
    tx_src_q.push_back(24'h999999);
    cpol_i = 1'b0; cpha_i = 1'b0; sck_i = 1'b0; sdi_i = 1'b1;
    tick(4);
    cs_i = 1'b0;
    tick(H);
    for (int b = 0; b < 5; b++) begin
      tick(H); sck_i = 1'b1; tick(H); sck_i = 1'b0;
    end
    reset_i = 1'b1;
    tick(2);
    check("midrst_oe", 32'(sdo_oe_o), 32'd0);
    check("midrst_sdo", 32'(sdo_o), 32'd0);
    reset_i = 1'b0;
    for (int b = 0; b < W; b++) begin
      tick(H); sck_i = 1'b1; tick(H); sck_i = 1'b0;
    end
    tick(H);
    check("midrst_no_rx", 32'(rx_valid_o), 32'd0);
    check("midrst_oe_held", 32'(sdo_oe_o), 32'd0);
    cs_i = 1'b1;
    tick(8);
    check("tx_pulses_midrst", 32'(tx_pulses - p), 32'd1);

    // cs rises after 10 bits; only the following full word is reported.
    p = tx_pulses;
    tx_src_q.push_back(24'h3C3C3C);
    mosi_q.push_back(24'h3C5A96);
    spi_frame(1'b0, 1'b0, 1, 10);
    check("abort_no_rx", 32'(rx_valid_o), 32'd0);
    tx_src_q.push_back(24'h5A5A5A);
    mosi_q.push_back(24'hFFFFFF);
    exp_rx_q.push_back(24'hFFFFFF);
    exp_miso_q.push_back(24'h5A5A5A);
    spi_frame(1'b0, 1'b0, 1, W);
    check("tx_pulses_abort", 32'(tx_pulses - p), 32'd2);

    tick(10);
    check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
